module_mult_seq: RTL and testbench
==================================

Name: module_mult_seq

Overview:
- Sequential multiplier that acts as the responder to the operand-load FSM.
- On an init request it captures the two 4-bit keypad operands a and b from the operand shift register, and iterates one partial-product step per clock.
- It then presents the product on mult with a one-cycle valid pulse.
- It sits between the operand register and the top-level mult output.

Parameters:
- N, 4, operand width in bits; product width is 2N.
- SIGNED, 0, 0 = unsigned shift-add; 1 = two's-complement radix-2 Booth.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- init  input  1  start request from operand FSM; sampled only in IDLE.
- a  input  N  multiplicand; captured on the accepted init cycle.
- b  input  N  multiplier; captured on the accepted init cycle.
- mult  output  2N  product; holds the last result until the next completion.
- valid  output  1  one-cycle pulse coincident with a mult update.
- busy  output  1  high while an operation is in progress (CALC and DONE).

Behaviour:
- Reset (rst low, async): state=IDLE, mult=0, valid=0, busy=0, acc=0, q=0, q_1=0, cnt=0.
- Internal registers:
  - m (N+1 bits, multiplicand extended).
  - acc (N+1 bits).
  - q (N bits).
  - q_1 (1 bit, Booth only).
  - cnt (clog2(N+1) bits).
- States: IDLE, CALC, DONE.
- IDLE:
  - If init=1: m<=ext(a), q<=b, acc<=0, q_1<=0, cnt<=N, go to CALC.
  - Extension is zero-extension if SIGNED=0, sign-extension if SIGNED=1.
  - If init=0: stay.
- CALC, one step per cycle, cnt<=cnt-1:
  - SIGNED=0: sum = acc + (q[0] ? m : 0), N+1 bits keeping the carry. Then {acc,q} <= logical right shift of {sum,q} by 1.
  - SIGNED=1: {q[0],q_1}=01 -> sum=acc+m; 10 -> sum=acc-m; 00/11 -> sum=acc. Then {acc,q,q_1} <= arithmetic right shift of {sum,q,q_1} by 1.
  - When cnt reaches 1 during a step, go to DONE after that step.
- DONE: mult <= {acc[N-1:0], q}, valid<=1 for exactly this cycle, busy stays 1. Return to IDLE next cycle.
- busy: 1 in CALC and DONE, 0 in IDLE. It rises the cycle after init is accepted.
- Latency: init accepted at edge k -> valid high in cycle k+N+1. mult is valid in the same cycle as valid and stays stable afterwards.
- Throughput: a new init is accepted once back in IDLE, so one operation per N+2 cycles. With init held high continuously, operations run back-to-back.
- init while busy (CALC or DONE) is ignored. Changes on a/b after capture have no effect on the operation in flight.
- Width rules:
  - The acc carry bit (unsigned) or guard bit (signed) prevents overflow, e.g. unsigned 15*15 and signed -8*-8.
  - The product always fits 2N bits; no saturation.
- Reset mid-operation aborts immediately to reset values. mult clears to 0 and no valid pulse is produced.
- N=1 is legal: one CALC step.

Decomposition:
- Package mult_pkg: state enum state_t {IDLE, CALC, DONE}; localparam function for counter width clog2(N+1).
- One natural combinational sub-module: module_mult_step. It takes acc, q, q_1, m and SIGNED, and returns the next acc/q/q_1 (add/sub plus shift). It is instantiated once in the datapath.

Test Plan:
- SIGNED=0, a=3, b=5, init pulse at cycle 0 -> busy high cycles 1..5, valid at cycle 5, mult=8'h0F.
- SIGNED=0, a=15, b=15 -> mult=8'hE1 (225), carry path exercised; a=0, b=9 -> mult=8'h00 with valid still pulsed.
- SIGNED=1:
  - a=-8 (4'h8), b=-8 -> mult=8'h40 (64).
  - a=-3 (4'hD), b=5 -> mult=8'hF1 (-15).
  - a=7, b=-1 (4'hF) -> mult=8'hF9 (-7).
- Second init and a/b changes (a=9, b=9) during CALC of 2*3 -> ignored; result 8'h06, single valid pulse. A later init in IDLE gives 8'h51.
- rst asserted low in the middle of CALC -> all outputs 0 asynchronously, no valid pulse. After release, init with a=4, b=4 -> mult=8'h10 at N+1 cycles.
- init held high for 3*(N+2) cycles with a=2, b=7 -> three valid pulses spaced N+2 cycles apart, each with mult=8'h0E.

Source files
------------

// File: rtl/module_mult_seq_pkg.sv
// Shared types and helpers for the sequential multiplier.
// The FSM state encoding and the step-counter width live here.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter must hold the value N itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/module_mult_seq_if.sv
// Operand/result bundle between the operand FSM (master) and the multiplier (slave).
interface module_mult_seq_if #(
    parameter int N = 4
);
    logic           init;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] mult;
    logic           valid;
    logic           busy;

    modport master (output init, output a, output b, input mult, input valid, input busy);
    modport slave  (input init, input a, input b, output mult, output valid, output busy);
endinterface

// File: rtl/module_mult_seq_step.sv
// One partial-product iteration: conditional add (unsigned) or Booth add/sub (signed),
// followed by a one-bit right shift of the {acc, q, q_1} register chain.
module module_mult_step #(
    parameter int N      = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic [N:0]   acc_i,
    input  logic [N-1:0] q_i,
    input  logic         q1_i,
    input  logic [N:0]   m_i,
    output logic [N:0]   acc_o,
    output logic [N-1:0] q_o,
    output logic         q1_o
);

    logic [N:0]     sum_s;
    logic           fill_s;
    logic [2*N+1:0] shift_s;

    // Add/subtract selection then shift; the fill bit makes the shift logical or arithmetic.
    always_comb begin
        sum_s = acc_i;
        if (SIGNED) begin
            case ({q_i[0], q1_i})
                2'b01:   sum_s = acc_i + m_i;
                2'b10:   sum_s = acc_i - m_i;
                default: sum_s = acc_i;
            endcase
            fill_s = sum_s[N];
        end else begin
            if (q_i[0]) begin
                sum_s = acc_i + m_i;
            end else begin
                sum_s = acc_i;
            end
            fill_s = 1'b0;
        end
        shift_s = {fill_s, sum_s, q_i};
        acc_o   = shift_s[2*N+1:N+1];
        q_o     = shift_s[N:1];
        q1_o    = shift_s[0];
    end

endmodule

// File: rtl/module_mult_seq.sv
// Sequential N x N multiplier: captures operands on init, runs N shift-add or Booth
// steps, then presents the 2N-bit product with a one-cycle valid pulse.
module module_mult_seq
    import mult_pkg::*;
#(
    parameter int N      = 4,
    parameter bit SIGNED = 1'b0
) (
    input logic               clk,
    input logic               rst,
    module_mult_seq_if.slave  bus
);

    localparam int CW = cnt_width(N);

    state_t         state_q, state_d;
    logic [N:0]     m_q, m_d;
    logic [N:0]     acc_q, acc_d;
    logic [N-1:0]   q_q, q_d;
    logic           q1_q, q1_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] mult_q, mult_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;

    logic [N:0]     a_ext_s;
    logic [N:0]     acc_step_s;
    logic [N-1:0]   q_step_s;
    logic           q1_step_s;

    assign a_ext_s = SIGNED ? {bus.a[N-1], bus.a} : {1'b0, bus.a};

    module_mult_step #(
        .N      (N),
        .SIGNED (SIGNED)
    ) u_step (
        .acc_i (acc_q),
        .q_i   (q_q),
        .q1_i  (q1_q),
        .m_i   (m_q),
        .acc_o (acc_step_s),
        .q_o   (q_step_s),
        .q1_o  (q1_step_s)
    );

    // Next-state and datapath control; the result is latched on the final step so valid lands in DONE.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        mult_d  = mult_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.init) begin
                    m_d     = a_ext_s;
                    q_d     = bus.b;
                    acc_d   = '0;
                    q1_d    = 1'b0;
                    cnt_d   = CW'(N);
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                acc_d = acc_step_s;
                q_d   = q_step_s;
                q1_d  = q1_step_s;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    mult_d  = {acc_step_s[N-1:0], q_step_s};
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            mult_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            mult_q  <= mult_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.mult  = mult_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_module_mult_seq.sv
// Bench for module_mult_seq: unsigned and Booth instances side by side, a vector table,
// a product scoreboard popped on every valid pulse, and hand-written multi-cycle sequences.
module tb_module_mult_seq;

    localparam int N = 4;

    typedef struct {
        bit             sgn;
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [2*N-1:0] exp_uns[$];
    logic [2*N-1:0] exp_sgn[$];
    vec_t           vecs[10];

    module_mult_seq_if #(.N(N)) if_uns ();
    module_mult_seq_if #(.N(N)) if_sgn ();

    module_mult_seq #(.N(N), .SIGNED(1'b0)) u_uns (.clk(clk), .rst(rst), .bus(if_uns));
    module_mult_seq #(.N(N), .SIGNED(1'b1)) u_sgn (.clk(clk), .rst(rst), .bus(if_sgn));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [2*N-1:0] model(input bit sgn, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] r;
        if (sgn) r = $signed(a) * $signed(b);
        else     r = a * b;
        return r;
    endfunction

    function automatic logic get_valid(input bit sgn);
        return sgn ? if_sgn.valid : if_uns.valid;
    endfunction

    function automatic logic get_busy(input bit sgn);
        return sgn ? if_sgn.busy : if_uns.busy;
    endfunction

    function automatic logic [2*N-1:0] get_mult(input bit sgn);
        return sgn ? if_sgn.mult : if_uns.mult;
    endfunction

    task automatic drive(input bit sgn, input logic init, input logic [N-1:0] a, input logic [N-1:0] b);
        if (sgn) begin
            if_sgn.init = init; if_sgn.a = a; if_sgn.b = b;
        end else begin
            if_uns.init = init; if_uns.a = a; if_uns.b = b;
        end
    endtask

    task automatic push(input bit sgn, input logic [2*N-1:0] e);
        if (sgn) exp_sgn.push_back(e);
        else     exp_uns.push_back(e);
    endtask

    // Wait (bounded) for valid starting at cycle 'start'; returns the cycle it was seen in.
    task automatic wait_valid(input bit sgn, input int start, output int lat);
        lat = start;
        while (get_valid(sgn) !== 1'b1 && lat < 2*N+4) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // One operation: init pulse, scrambled operands after capture, latency/busy/hold checks.
    task automatic run_op(input bit sgn, input logic [N-1:0] a, input logic [N-1:0] b, input logic [2*N-1:0] e);
        int lat;
        @(negedge clk);
        drive(sgn, 1'b1, a, b);
        push(sgn, e);
        @(negedge clk);
        drive(sgn, 1'b0, N'($urandom), N'($urandom));
        check("busy_rise", 32'(get_busy(sgn)), 32'd1);
        wait_valid(sgn, 1, lat);
        check("latency", 32'(lat), 32'(N+1));
        @(negedge clk);
        check("busy_fall", 32'(get_busy(sgn)), 32'd0);
        check("mult_hold", 32'(get_mult(sgn)), 32'(e));
    endtask

    // Scoreboard: every valid pulse pops one expected product.
    always @(negedge clk) begin
        if (if_uns.valid === 1'b1) begin
            if (exp_uns.size() == 0) begin
                checks++; errors++;
                $display("FAIL uns_unexpected_valid actual=%0h required=no_pulse", if_uns.mult);
            end else begin
                check("uns_mult", 32'(if_uns.mult), 32'(exp_uns.pop_front()));
            end
        end
        if (if_sgn.valid === 1'b1) begin
            if (exp_sgn.size() == 0) begin
                checks++; errors++;
                $display("FAIL sgn_unexpected_valid actual=%0h required=no_pulse", if_sgn.mult);
            end else begin
                check("sgn_mult", 32'(if_sgn.mult), 32'(exp_sgn.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int npos;
        int pos[3];
        checks = 0;
        errors = 0;
        vecs[0] = '{1'b0, 4'd3,  4'd5,  8'h0F};
        vecs[1] = '{1'b0, 4'd15, 4'd15, 8'hE1};
        vecs[2] = '{1'b0, 4'd0,  4'd9,  8'h00};
        vecs[3] = '{1'b0, 4'd2,  4'd3,  8'h06};
        vecs[4] = '{1'b0, 4'd12, 4'd10, 8'h78};
        vecs[5] = '{1'b1, 4'h8,  4'h8,  8'h40};
        vecs[6] = '{1'b1, 4'hD,  4'h5,  8'hF1};
        vecs[7] = '{1'b1, 4'h7,  4'hF,  8'hF9};
        vecs[8] = '{1'b1, 4'h8,  4'h7,  8'hC8};
        vecs[9] = '{1'b1, 4'h3,  4'h3,  8'h09};

        rst = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        drive(1'b1, 1'b0, 4'd0, 4'd0);
        repeat (2) @(negedge clk);
        check("rst_uns_mult",  32'(if_uns.mult),  32'd0);
        check("rst_uns_valid", 32'(if_uns.valid), 32'd0);
        check("rst_uns_busy",  32'(if_uns.busy),  32'd0);
        check("rst_sgn_mult",  32'(if_sgn.mult),  32'd0);
        check("rst_sgn_valid", 32'(if_sgn.valid), 32'd0);
        check("rst_sgn_busy",  32'(if_sgn.busy),  32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        for (int i = 0; i < 12; i++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            bit           rs;
            ra = N'($urandom);
            rb = N'($urandom);
            rs = 1'(i % 2);
            run_op(rs, ra, rb, model(rs, ra, rb));
        end

        // init and operand changes during CALC must not disturb the operation in flight.
        @(negedge clk);
        drive(1'b0, 1'b1, 4'd2, 4'd3);
        push(1'b0, 8'h06);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd2, 4'd3);
        @(negedge clk);
        drive(1'b0, 1'b1, 4'd9, 4'd9);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd9, 4'd9);
        wait_valid(1'b0, 3, lat);
        check("ignore_latency", 32'(lat), 32'(N+1));
        repeat (N+3) @(negedge clk);
        check("ignore_queue_empty", 32'(exp_uns.size()), 32'd0);
        run_op(1'b0, 4'd9, 4'd9, 8'h51);

        // Asynchronous reset in the middle of CALC aborts without a valid pulse.
        @(negedge clk);
        drive(1'b0, 1'b1, 4'd5, 4'd5);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'd5, 4'd5);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_uns_mult",  32'(if_uns.mult),  32'd0);
        check("arst_uns_valid", 32'(if_uns.valid), 32'd0);
        check("arst_uns_busy",  32'(if_uns.busy),  32'd0);
        check("arst_sgn_mult",  32'(if_sgn.mult),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (N+3) @(negedge clk);
        check("arst_no_valid", 32'(exp_uns.size()), 32'd0);
        check("arst_mult_zero", 32'(if_uns.mult), 32'd0);
        run_op(1'b0, 4'd4, 4'd4, 8'h10);

        // init held high: three back-to-back operations spaced N+2 cycles apart.
        @(negedge clk);
        drive(1'b0, 1'b1, 4'd2, 4'd7);
        for (int k = 0; k < 3; k++) push(1'b0, 8'h0E);
        npos = 0;
        for (int c = 1; c <= 3*(N+2) + 4; c++) begin
            @(negedge clk);
            if (c == 3*(N+2)) drive(1'b0, 1'b0, 4'd2, 4'd7);
            if (if_uns.valid === 1'b1) begin
                if (npos < 3) pos[npos] = c;
                npos++;
            end
        end
        check("b2b_count", 32'(npos), 32'd3);
        if (npos >= 3) begin
            check("b2b_first", 32'(pos[0]), 32'(N+1));
            check("b2b_gap1", 32'(pos[1] - pos[0]), 32'(N+2));
            check("b2b_gap2", 32'(pos[2] - pos[1]), 32'(N+2));
        end

        repeat (4) @(negedge clk);
        check("final_uns_queue", 32'(exp_uns.size()), 32'd0);
        check("final_sgn_queue", 32'(exp_sgn.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
